// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encodings, port IDs
// and the address alignment helper used when latching an access.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  // Word accesses are forced onto a word boundary; byte accesses keep their lane.
  function automatic logic [1:0] align_lsb(input logic byteop, input logic [1:0] lsb);
    return byteop ? lsb : 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner selection between the IF and DM requesters.
// Default: data priority, with IF forced through after STARVE_MAX consecutive
// DM grants taken while IF was waiting.
// With MEM_ARB_RR_EN defined: strict round-robin on collisions, the
// starvation count is ignored.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic          if_req,
  input  logic          dm_req,
  input  logic [SW-1:0] starve_cnt,
  input  logic          last_grant,
  output logic          gnt_port
);

`ifdef MEM_ARB_RR_EN
  logic unused_starve;
  assign unused_starve = ^starve_cnt;

  // Collision goes to whichever port was not served last.
  always_comb begin
    gnt_port = dm_req ? PORT_DM : PORT_IF;
    if (if_req && dm_req)
      gnt_port = (last_grant == PORT_IF) ? PORT_DM : PORT_IF;
  end
`else
  logic unused_last;
  assign unused_last = last_grant;

  // Collision goes to DM unless IF has been passed over STARVE_MAX times.
  always_comb begin
    gnt_port = dm_req ? PORT_DM : PORT_IF;
    if (if_req && dm_req)
      gnt_port = (starve_cnt == SW'(STARVE_MAX)) ? PORT_IF : PORT_DM;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (DM).
// One access at a time: IDLE latches the winner, ACCESS strobes the memory,
// WAIT covers MEM_LAT read latency, DONE pulses the winner's ack.
// All outputs come straight from flops.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_grant).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic          dm_byteop,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_ack,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic          mem_byteop,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  state_e          state_q, state_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            last_q, last_d;
  logic            win_q, win_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_byteop_q, mem_byteop_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            if_ack_q, if_ack_d;
  logic            dm_ack_q, dm_ack_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     dm_rdata_q, dm_rdata_d;
  logic            busy_q, busy_d;
  logic            gnt_port;

  // IF addresses are word addresses; their low bits never reach the memory.
  logic unused_if_lsb;
  assign unused_if_lsb = ^if_addr[1:0];

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_grant (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (starve_q),
    .last_grant (last_q),
    .gnt_port   (gnt_port)
  );

  // Next-state, latched access fields, acks and read-data capture.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    last_d       = last_q;
    win_d        = win_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_byteop_d = mem_byteop_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          win_d    = gnt_port;
          last_d   = gnt_port;
          if (gnt_port == PORT_DM) begin
            mem_we_d     = dm_we;
            mem_byteop_d = dm_byteop;
            mem_addr_d   = {dm_addr[AW-1:2], align_lsb(dm_byteop, dm_addr[1:0])};
            mem_wdata_d  = dm_wdata;
            starve_d     = if_req ? starve_q + SW'(1) : '0;
          end else begin
            mem_we_d     = 1'b0;
            mem_byteop_d = 1'b0;
            mem_addr_d   = {if_addr[AW-1:2], 2'b00};
            mem_wdata_d  = '0;
            starve_d     = '0;
          end
        end
      end
      ACCESS: begin
        if (mem_we_q) begin
          state_d  = DONE;
          if_ack_d = (win_q == PORT_IF);
          dm_ack_d = (win_q == PORT_DM);
        end else begin
          state_d = WAIT;
          lat_d   = LW'(MEM_LAT);
        end
      end
      WAIT: begin
        if (lat_q == LW'(1)) begin
          state_d  = DONE;
          if_ack_d = (win_q == PORT_IF);
          dm_ack_d = (win_q == PORT_DM);
          if (win_q == PORT_IF) if_rdata_d = mem_rdata;
          else                  dm_rdata_d = mem_rdata;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any access without an ack.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      starve_q     <= '0;
      last_q       <= PORT_IF;
      win_q        <= PORT_IF;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_byteop_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      last_q       <= last_d;
      win_q        <= win_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_byteop_q <= mem_byteop_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign dm_ack     = dm_ack_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_byteop = mem_byteop_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT = 2, STARVE_MAX = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        Clk, Reset_n;
  logic        if_req, dm_req, dm_we, dm_byteop;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we, mem_byteop, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4), .AW(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byteop(dm_byteop), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byteop(mem_byteop),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory stand-in: preset words while in reset, writes on mem_en & mem_we,
  // read data two cycles after the strobe, poison value otherwise.
  logic [31:0] mem [0:63];
  logic [31:0] rd_p1, rd_p2;
  always @(posedge Clk) begin
    if (!Reset_n) begin
      mem[0] <= 32'h0000_0000;
      mem[1] <= 32'h2000_0001;
      mem[2] <= 32'h1234_5678;
      mem[4] <= 32'hCAFE_F00D;
    end else if (mem_en && mem_we) begin
      if (mem_byteop) mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
      else            mem[mem_addr[7:2]] <= mem_wdata;
    end
    rd_p1 <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  // Waits (bounded) for the next ack; cyc = -1 if none arrives.
  task automatic wait_ack(output logic got_if, output logic got_dm, output int cyc);
    got_if = 1'b0; got_dm = 1'b0; cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (if_ack || dm_ack) begin
        got_if = if_ack; got_dm = dm_ack; cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    @(negedge Clk);
    checks++; if ({if_ack, dm_ack, mem_en, mem_we, mem_byteop, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {if_ack, dm_ack, mem_en, mem_we, mem_byteop, busy}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_dm_rdata got=%h exp=0", dm_rdata); end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fetch;
    @(negedge Clk);
    if_addr = 32'h0000_0004; if_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      checks++; if (mem_en !== (k == 1)) begin errors++; $display("FAIL fetch_mem_en k=%0d got=%b", k, mem_en); end
      checks++; if (if_ack !== (k == 4)) begin errors++; $display("FAIL fetch_if_ack k=%0d got=%b", k, if_ack); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy k=%0d got=%b exp=1", k, busy); end
      if (k == 1) begin
        checks++; if (mem_addr !== 32'h4 || mem_we !== 1'b0) begin
          errors++; $display("FAIL fetch_mem_addr got=%h we=%b exp=4 we=0", mem_addr, mem_we); end
      end
      if (k == 4) begin
        checks++; if (if_rdata !== 32'h2000_0001) begin errors++; $display("FAIL fetch_rdata got=%h exp=20000001", if_rdata); end
        if_req = 1'b0;
      end
    end
    @(negedge Clk);
    checks++; if (busy !== 1'b0 || if_ack !== 1'b0) begin errors++; $display("FAIL fetch_idle busy=%b ack=%b exp=0 0", busy, if_ack); end
  endtask

  task automatic test_reset_midwait;
    @(negedge Clk);
    if_addr = 32'h0000_0010; if_req = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy_before got=%b exp=1", busy); end
    Reset_n = 1'b0;
    #1;
    checks++; if ({if_ack, dm_ack, mem_en, busy} !== 4'b0) begin
      errors++; $display("FAIL midwait_abort got=%b exp=0000", {if_ack, dm_ack, mem_en, busy}); end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      checks++; if (if_ack !== (k == 4)) begin errors++; $display("FAIL midwait_if_ack k=%0d got=%b", k, if_ack); end
      if (k == 1) begin
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin
          errors++; $display("FAIL midwait_access en=%b addr=%h exp=1 10", mem_en, mem_addr); end
      end
      if (k == 4) begin
        checks++; if (if_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL midwait_rdata got=%h exp=cafef00d", if_rdata); end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_byte_store;
    @(negedge Clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_byteop = 1'b1; dm_addr = 32'h13; dm_wdata = 32'h5555_55AB;
    @(negedge Clk);
    checks++; if ({mem_en, mem_we, mem_byteop} !== 3'b111) begin
      errors++; $display("FAIL store_strobes got=%b exp=111", {mem_en, mem_we, mem_byteop}); end
    checks++; if (mem_addr !== 32'h13) begin errors++; $display("FAIL store_addr got=%h exp=13", mem_addr); end
    checks++; if (mem_wdata[7:0] !== 8'hAB) begin errors++; $display("FAIL store_wdata got=%h exp=ab", mem_wdata[7:0]); end
    checks++; if (dm_ack !== 1'b0) begin errors++; $display("FAIL store_early_ack got=%b exp=0", dm_ack); end
    @(negedge Clk);
    checks++; if (dm_ack !== 1'b1 || if_ack !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL store_ack dm=%b if=%b en=%b exp=1 0 0", dm_ack, if_ack, mem_en); end
    dm_req = 1'b0; dm_we = 1'b0; dm_byteop = 1'b0;
    @(negedge Clk);
    checks++; if (dm_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL store_done ack=%b busy=%b exp=0 0", dm_ack, busy); end
  endtask

  task automatic test_word_align;
    logic [31:0] addrs [0:1];
    logic [31:0] maddr [0:1];
    logic [31:0] rdat  [0:1];
    addrs[0] = 32'h7;  maddr[0] = 32'h4;  rdat[0] = 32'h2000_0001;
    addrs[1] = 32'h12; maddr[1] = 32'h10; rdat[1] = 32'hABFE_F00D;
    for (int v = 0; v < 2; v++) begin
      @(negedge Clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_byteop = 1'b0; dm_addr = addrs[v];
      for (int k = 1; k <= 4; k++) begin
        @(negedge Clk);
        if (k == 1) begin
          checks++; if (mem_addr !== maddr[v] || {mem_en, mem_we, mem_byteop} !== 3'b100) begin
            errors++; $display("FAIL align_addr v=%0d got=%h ctl=%b exp=%h 100", v, mem_addr, {mem_en, mem_we, mem_byteop}, maddr[v]); end
        end
        checks++; if (dm_ack !== (k == 4)) begin errors++; $display("FAIL align_ack v=%0d k=%0d got=%b", v, k, dm_ack); end
        if (k == 4) begin
          checks++; if (dm_rdata !== rdat[v]) begin errors++; $display("FAIL align_rdata v=%0d got=%h exp=%h", v, dm_rdata, rdat[v]); end
          dm_req = 1'b0;
        end
      end
    end
    checks++; if (if_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL if_rdata_hold got=%h exp=cafef00d", if_rdata); end
  endtask

  task automatic test_protocol_violation;
    int acks;
    acks = 0;
    @(negedge Clk);
    if_addr = 32'h8; if_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (k == 2) if_req = 1'b0;
      if (if_ack) acks++;
      if (k == 4) begin
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h1234_5678) begin
          errors++; $display("FAIL viol_ack ack=%b rdata=%h exp=1 12345678", if_ack, if_rdata); end
      end
      if (k >= 5) begin
        checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin
          errors++; $display("FAIL viol_idle k=%0d busy=%b en=%b exp=0 0", k, busy, mem_en); end
      end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL viol_ack_count got=%0d exp=1", acks); end
  endtask

  task automatic test_collision;
    logic exp_dm [0:5];
    logic gi, gd;
    int   cyc;
`ifdef MEM_ARB_RR_EN
    exp_dm[0] = 1; exp_dm[1] = 0; exp_dm[2] = 1; exp_dm[3] = 0; exp_dm[4] = 1; exp_dm[5] = 0;
`else
    exp_dm[0] = 1; exp_dm[1] = 1; exp_dm[2] = 1; exp_dm[3] = 1; exp_dm[4] = 0; exp_dm[5] = 1;
`endif
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    if_addr = 32'h0; dm_addr = 32'h0; dm_we = 1'b0; dm_byteop = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_ack(gi, gd, cyc);
      checks++; if ({gi, gd} !== {~exp_dm[g], exp_dm[g]}) begin
        errors++; $display("FAIL collide_order g=%0d got if/dm=%b%b exp=%b%b", g, gi, gd, ~exp_dm[g], exp_dm[g]); end
      checks++; if (cyc != ((g == 0) ? 4 : 5)) begin
        errors++; $display("FAIL collide_spacing g=%0d got=%0d exp=%0d", g, cyc, (g == 0) ? 4 : 5); end
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collide_idle busy=%b exp=0", busy); end
  endtask

  initial begin
    Reset_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_byteop = 1'b0; dm_addr = '0; dm_wdata = '0;
    test_reset;
    test_fetch;
    test_reset_midwait;
    test_byte_store;
    test_word_align;
    test_protocol_violation;
    test_collision;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
